// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types: FSM state and read-owner encoding.
// Build option: MEM_ARBITER_BURST_EN enables loader burst lock.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORE = 2'd1,
    LOAD = 2'd2
  } arb_state_e;

  typedef logic [1:0] owner_t;

  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_CORE = 2'd1;
  localparam owner_t OWN_LOAD = 2'd2;

  function automatic owner_t rd_owner_of(
    input logic core_rd,
    input logic ld_rd
  );
    owner_t o;
    o = OWN_NONE;
    if (core_rd)
      o = OWN_CORE;
    else if (ld_rd)
      o = OWN_LOAD;
    return o;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter bus bundle: core port, loader port, data-memory drive.
// slave = arbiter view, master = requesters and memory view.
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt;
  logic          core_stall;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;

  logic          ld_req;
  logic          ld_we;
  logic          ld_lock;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic [DW-1:0] ld_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  ld_req, ld_we, ld_lock, ld_addr, ld_wdata,
    input  mem_rdata,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    output ld_gnt, ld_rvalid, ld_rdata,
    output mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output ld_req, ld_we, ld_lock, ld_addr, ld_wdata,
    output mem_rdata,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    input  ld_gnt, ld_rvalid, ld_rdata,
    input  mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/mem_arbiter_rd_return.sv
// rd_return: one-cycle read-return register steered to the read owner.
// The non-owning port keeps its last rdata.
module rd_return
  import mem_arb_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  owner_t        rd_owner,
  input  logic [DW-1:0] mem_rdata,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata
);

  logic          core_rvalid_q, core_rvalid_d;
  logic          ld_rvalid_q, ld_rvalid_d;
  logic [DW-1:0] core_rdata_q, core_rdata_d;
  logic [DW-1:0] ld_rdata_q, ld_rdata_d;

  always_comb begin
    core_rvalid_d = (rd_owner == OWN_CORE);
    ld_rvalid_d   = (rd_owner == OWN_LOAD);
    core_rdata_d  = core_rdata_q;
    ld_rdata_d    = ld_rdata_q;
    if (core_rvalid_d)
      core_rdata_d = mem_rdata;
    if (ld_rvalid_d)
      ld_rdata_d = mem_rdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_rvalid_q <= 1'b0;
      ld_rvalid_q   <= 1'b0;
      core_rdata_q  <= '0;
      ld_rdata_q    <= '0;
    end else begin
      core_rvalid_q <= core_rvalid_d;
      ld_rvalid_q   <= ld_rvalid_d;
      core_rdata_q  <= core_rdata_d;
      ld_rdata_q    <= ld_rdata_d;
    end
  end

  assign core_rvalid = core_rvalid_q;
  assign core_rdata  = core_rdata_q;
  assign ld_rvalid   = ld_rvalid_q;
  assign ld_rdata    = ld_rdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: core/loader round-robin arbiter for one data memory.
// Define MEM_ARBITER_BURST_EN to let a locked loader keep the port.
module mem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_arbiter_if.slave bus
);
  import mem_arb_pkg::*;

  arb_state_e    state_q, state_d;
  logic          hold;
  logic          ld_win;
  logic          core_gnt;
  logic          ld_gnt;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          rd;
  logic          wr;
  owner_t        rd_owner;

`ifdef MEM_ARBITER_BURST_EN
  localparam int CW = $clog2(MAX_BURST);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  // burst_cnt = beats already taken in this locked run, minus one
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;

  always_comb begin
    hold = (state_q == LOAD) && bus.ld_lock &&
           (burst_cnt_q < CNT_MAX);
    burst_cnt_d = '0;
    if (ld_gnt && bus.ld_lock && state_q == LOAD)
      burst_cnt_d = (burst_cnt_q == CNT_MAX) ?
                    burst_cnt_q : burst_cnt_q + CW'(1);
  end
`else
  localparam int unused_max_burst = MAX_BURST;
  logic unused_lock;
  assign unused_lock = bus.ld_lock;
  assign hold = 1'b0;
`endif

  always_comb begin
    ld_win   = bus.ld_req &&
               (!bus.core_req || hold || state_q == CORE);
    core_gnt = reset_n && bus.core_req && !ld_win;
    ld_gnt   = reset_n && ld_win;
  end

  always_comb begin
    state_d = IDLE;
    if (core_gnt)
      state_d = CORE;
    else if (ld_gnt)
      state_d = LOAD;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
`ifdef MEM_ARBITER_BURST_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MEM_ARBITER_BURST_EN
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

  always_comb begin
    addr  = '0;
    wdata = '0;
    rd    = 1'b0;
    wr    = 1'b0;
    unique case (1'b1)
      core_gnt: begin
        addr  = bus.core_addr;
        wdata = bus.core_wdata;
        rd    = !bus.core_we;
        wr    = bus.core_we;
      end
      ld_gnt: begin
        addr  = bus.ld_addr;
        wdata = bus.ld_wdata;
        rd    = !bus.ld_we;
        wr    = bus.ld_we;
      end
      default: ;
    endcase
  end

  assign bus.core_gnt   = core_gnt;
  assign bus.ld_gnt     = ld_gnt;
  assign bus.core_stall = reset_n && bus.core_req && !core_gnt;
  assign bus.mem_addr   = addr;
  assign bus.mem_wdata  = wdata;
  assign bus.mem_read   = rd;
  assign bus.mem_write  = wr;

  assign rd_owner = rd_owner_of(core_gnt && !bus.core_we,
                                ld_gnt && !bus.ld_we);

  rd_return #(
    .DW(DW)
  ) u_rd_return (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_owner   (rd_owner),
    .mem_rdata  (bus.mem_rdata),
    .core_rvalid(bus.core_rvalid),
    .core_rdata (bus.core_rdata),
    .ld_rvalid  (bus.ld_rvalid),
    .ld_rdata   (bus.ld_rdata)
  );

endmodule
